// File: rtl/n_bit_shift_reg_if.sv
// Command/data bundle for n_bit_shift_reg: parallel load, shift start controls and
// the register/handshake outputs. The master drives commands and the slave is the shifter.
interface n_bit_shift_reg_if #(
    parameter int SIZE = 10
);
    localparam int CNT_W = $clog2(SIZE + 1);

    logic             pen;
    logic [SIZE-1:0]  pin;
    logic             sen;
    logic             dir;
    logic             arith;
    logic             sin;
    logic [CNT_W-1:0] amt;
    logic [SIZE-1:0]  pout;
    logic             busy;
    logic             done;
    logic             sout;

    modport master (
        output pen, pin, sen, dir, arith, sin, amt,
        input  pout, busy, done, sout
    );

    modport slave (
        input  pen, pin, sen, dir, arith, sin, amt,
        output pout, busy, done, sout
    );
endinterface

// File: rtl/n_bit_shift_reg.sv
// Parallel-load register with multi-position shifting, one position per clock.
// It supports left, logical right and arithmetic right shifts, uses a start/busy/done handshake and has a registered serial output.
module n_bit_shift_reg #(
    parameter int SIZE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    n_bit_shift_reg_if.slave      bus
);
    localparam int CNT_W = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [SIZE-1:0]  pout_q;
    logic             sout_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             arith_q;

    logic [SIZE-1:0]  pout_d;
    logic             sout_d;
    logic [CNT_W-1:0] amt_clamped;
    logic             fill;

    // Requests longer than the register width clamp to a full-width shift.
    always_comb begin
        amt_clamped = bus.amt;
        if (bus.amt > CNT_W'(SIZE)) begin
            amt_clamped = CNT_W'(SIZE);
        end
    end

    // One-position shift using the direction and mode latched at start.
    always_comb begin
        fill   = arith_q ? pout_q[SIZE-1] : bus.sin;
        pout_d = {pout_q[SIZE-2:0], bus.sin};
        sout_d = pout_q[SIZE-1];
        if (dir_q) begin
            pout_d = {fill, pout_q[SIZE-1:1]};
            sout_d = pout_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pout_q  <= '0;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            case (state_q)
                SHIFT: begin
                    pout_q <= pout_d;
                    sout_q <= sout_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    // IDLE and DONE accept commands; a load beats a simultaneous start.
                    if (bus.pen) begin
                        pout_q  <= bus.pin;
                        state_q <= IDLE;
                    end else if (bus.sen) begin
                        dir_q   <= bus.dir;
                        arith_q <= bus.arith;
                        cnt_q   <= amt_clamped;
                        state_q <= (amt_clamped == '0) ? DONE : SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.pout = pout_q;
    assign bus.sout = sout_q;
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_n_bit_shift_reg.sv
// Directed bench for n_bit_shift_reg at SIZE=8. It checks reset, load, each shift mode,
// amount clamping, zero amounts, priority/ignore rules, back-to-back starts and abort by reset.
module tb_n_bit_shift_reg;
    localparam int SIZE  = 8;
    localparam int CNT_W = $clog2(SIZE + 1);

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    n_bit_shift_reg_if #(.SIZE(SIZE)) bus ();

    n_bit_shift_reg #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Sample/drive point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [SIZE-1:0] v);
        bus.pen = 1'b1;
        bus.pin = v;
        tick();
        bus.pen = 1'b0;
    endtask

    // Issue a start and run until the done cycle. The task returns the busy count and done count.
    // nbusy = -1 means done never arrived within the budget.
    task automatic do_shift(input logic [CNT_W-1:0] amt, input logic d, input logic ar,
                            input logic s, output int nbusy, output int ndone);
        bus.sen   = 1'b1;
        bus.amt   = amt;
        bus.dir   = d;
        bus.arith = ar;
        bus.sin   = s;
        tick();
        bus.sen = 1'b0;
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy && bus.done) nbusy = 100;
            if (bus.done) begin
                ndone = 1;
                break;
            end
            if (bus.busy) nbusy++;
            tick();
        end
        if (ndone == 0) nbusy = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.pout !== 8'h00) begin n_err++; $display("FAIL reset_pout got=%h exp=00", bus.pout); end
        n_cmp++; if (bus.busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)  begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.sout !== 1'b0)  begin n_err++; $display("FAIL reset_sout got=%b exp=0", bus.sout); end
        rst = 1'b1;
        load(8'hA5);
        n_cmp++; if (bus.pout !== 8'hA5) begin n_err++; $display("FAIL load_pout got=%h exp=a5", bus.pout); end
    endtask

    task automatic test_left();
        int nb, nd;
        do_shift(4'd3, 1'b0, 1'b0, 1'b0, nb, nd);
        n_cmp++; if (nb !== 3)          begin n_err++; $display("FAIL left_busy_cycles got=%0d exp=3", nb); end
        n_cmp++; if (bus.pout !== 8'h28) begin n_err++; $display("FAIL left_pout got=%h exp=28", bus.pout); end
        n_cmp++; if (bus.sout !== 1'b1)  begin n_err++; $display("FAIL left_sout got=%b exp=1", bus.sout); end
        tick();
        n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL left_done_width got done=%b busy=%b exp 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_right();
        int nb, nd;
        load(8'h96);
        do_shift(4'd2, 1'b1, 1'b1, 1'b0, nb, nd);
        n_cmp++; if (nb !== 2)          begin n_err++; $display("FAIL arith_busy_cycles got=%0d exp=2", nb); end
        n_cmp++; if (bus.pout !== 8'hE5) begin n_err++; $display("FAIL arith_pout got=%h exp=e5", bus.pout); end
        n_cmp++; if (bus.sout !== 1'b1)  begin n_err++; $display("FAIL arith_sout got=%b exp=1", bus.sout); end
        tick();
        load(8'h96);
        n_cmp++; if (bus.sout !== 1'b1)  begin n_err++; $display("FAIL load_keeps_sout got=%b exp=1", bus.sout); end
        do_shift(4'd2, 1'b1, 1'b0, 1'b0, nb, nd);
        n_cmp++; if (bus.pout !== 8'h25) begin n_err++; $display("FAIL logic_right_pout got=%h exp=25", bus.pout); end
        tick();
    endtask

    task automatic test_clamp_zero();
        int nb, nd;
        load(8'h00);
        do_shift(4'd12, 1'b1, 1'b0, 1'b1, nb, nd);
        n_cmp++; if (nb !== 8)          begin n_err++; $display("FAIL clamp_busy_cycles got=%0d exp=8", nb); end
        n_cmp++; if (bus.pout !== 8'hFF) begin n_err++; $display("FAIL clamp_pout got=%h exp=ff", bus.pout); end
        n_cmp++; if (bus.sout !== 1'b0)  begin n_err++; $display("FAIL clamp_sout got=%b exp=0", bus.sout); end
        tick();
        do_shift(4'd0, 1'b0, 1'b0, 1'b0, nb, nd);
        n_cmp++; if (nb !== 0 || nd !== 1) begin n_err++; $display("FAIL zero_amt busy=%0d done=%0d exp 0/1", nb, nd); end
        n_cmp++; if (bus.pout !== 8'hFF) begin n_err++; $display("FAIL zero_amt_pout got=%h exp=ff", bus.pout); end
        tick();
    endtask

    task automatic test_priority();
        int nb;
        bus.pen = 1'b1; bus.pin = 8'h5A;
        bus.sen = 1'b1; bus.amt = 4'd3; bus.dir = 1'b0;
        tick();
        bus.pen = 1'b0; bus.sen = 1'b0;
        n_cmp++; if (bus.pout !== 8'h5A || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL pen_over_sen pout=%h busy=%b done=%b exp 5a/0/0", bus.pout, bus.busy, bus.done);
        end
        tick();
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL sen_dropped busy=%b done=%b exp 0/0", bus.busy, bus.done);
        end
        // Load, direction and amount changes mid-shift must not disturb the result.
        load(8'hA5);
        bus.sen = 1'b1; bus.amt = 4'd3; bus.dir = 1'b0; bus.arith = 1'b0; bus.sin = 1'b0;
        tick();
        bus.sen = 1'b0;
        bus.pen = 1'b1; bus.pin = 8'h33; bus.dir = 1'b1; bus.amt = 4'd7;
        nb = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin nb = i; break; end
            tick();
        end
        bus.pen = 1'b0;
        n_cmp++; if (nb !== 3)          begin n_err++; $display("FAIL ignore_busy_cycles got=%0d exp=3", nb); end
        n_cmp++; if (bus.pout !== 8'h28) begin n_err++; $display("FAIL ignore_pout got=%h exp=28", bus.pout); end
        tick();
    endtask

    task automatic test_back_to_back();
        int nb, nd;
        load(8'h01);
        do_shift(4'd1, 1'b0, 1'b0, 1'b0, nb, nd);
        n_cmp++; if (bus.pout !== 8'h02) begin n_err++; $display("FAIL b2b_first_pout got=%h exp=02", bus.pout); end
        do_shift(4'd2, 1'b0, 1'b0, 1'b1, nb, nd);
        n_cmp++; if (nb !== 2)          begin n_err++; $display("FAIL b2b_busy_cycles got=%0d exp=2", nb); end
        n_cmp++; if (bus.pout !== 8'h0B) begin n_err++; $display("FAIL b2b_second_pout got=%h exp=0b", bus.pout); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        load(8'hFF);
        bus.sen = 1'b1; bus.amt = 4'd5; bus.dir = 1'b0; bus.arith = 1'b0; bus.sin = 1'b0;
        tick();
        bus.sen = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.busy !== 1'b1 || bus.sout !== 1'b1) begin
            n_err++; $display("FAIL mid_pre_reset busy=%b sout=%b exp 1/1", bus.busy, bus.sout);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++; if (bus.pout !== 8'h00 || bus.busy !== 1'b0 || bus.sout !== 1'b0) begin
            n_err++; $display("FAIL mid_reset pout=%h busy=%b sout=%b exp 00/0/0", bus.pout, bus.busy, bus.sout);
        end
        for (int i = 0; i < 8; i++) begin
            if (bus.done) seen_done++;
            tick();
        end
        n_cmp++; if (seen_done !== 0) begin n_err++; $display("FAIL mid_reset_no_done got=%0d exp=0", seen_done); end
    endtask

    initial begin
        rst = 1'b0;
        bus.pen = 1'b0; bus.pin = '0; bus.sen = 1'b0; bus.dir = 1'b0;
        bus.arith = 1'b0; bus.sin = 1'b0; bus.amt = '0;
        test_reset();
        test_left();
        test_right();
        test_clamp_zero();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
